// File: rtl/capture_controller.sv
// capture_controller: sequences one logic-analyzer acquisition (arm, pre-fill, trigger search, post-fill, done)
// and drives the write side of the circular sample buffer.
module capture_controller #(
    parameter int CHANNELS = 8,
    parameter int ADDR_W = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_en,
    input  logic [CHANNELS-1:0] din,
    input  logic                arm,
    input  logic                abort,
    input  logic [CHANNELS-1:0] trig_mask,
    input  logic                trig_pol,
    input  logic [ADDR_W-1:0]   pre_count,
    input  logic [ADDR_W-1:0]   post_count,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [CHANNELS-1:0] wr_data,
    output logic [ADDR_W-1:0]   trig_addr,
    output logic                busy,
    output logic                done
);
    typedef enum logic [2:0] {IDLE, PRE, WAIT, POST, DONE} state_t;
    state_t state, state_n;
    logic [CHANNELS-1:0] din_q;
    logic [ADDR_W-1:0] ptr, cnt, cnt_inc;
    logic wr, hit, start;
    assign busy = (state == PRE) || (state == WAIT) || (state == POST);
    assign done = state == DONE;
    assign wr = sample_en & busy;
    assign start = arm & ((state == IDLE) || (state == DONE));
    assign cnt_inc = cnt + 1'b1;
    assign hit = |((trig_pol ? (~din & din_q) : (din & ~din_q)) & trig_mask);
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;
    always_comb begin
        state_n = state;
        if (abort) state_n = IDLE;
        else if (start) state_n = (pre_count == '0) ? WAIT : PRE;
        else if (wr)
            case (state)
                PRE:  state_n = (cnt_inc == pre_count) ? WAIT : PRE;
                WAIT: state_n = hit ? ((post_count == '0) ? DONE : POST) : WAIT;
                POST: state_n = (cnt == ADDR_W'(1)) ? DONE : POST;
                default: state_n = state;
            endcase
    end
    // Abort in a sample cycle drops that write entirely, not just the strobe.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_en <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            trig_addr <= '0;
            din_q <= '0;
            ptr <= '0;
            cnt <= '0;
        end else begin
            wr_en <= wr & ~abort;
            if (sample_en) din_q <= din;
            if (start & ~abort) begin
                ptr <= '0;
                cnt <= '0;
            end else if (wr & ~abort) begin
                wr_data <= din;
                wr_addr <= ptr;
                ptr <= ptr + 1'b1;
                if (state == PRE) cnt <= cnt_inc;
                else if (state == POST) cnt <= cnt - 1'b1;
                else if (hit) begin
                    trig_addr <= ptr;
                    cnt <= post_count;
                end
            end
        end
endmodule

// File: tb/tb_capture_controller.sv
// tb_capture_controller: scoreboard bench driving a 10-bit and a 4-bit address instance in lockstep.
module tb_capture_controller;
    logic clk, rst, sample_en, arm, abort, trig_pol;
    logic [7:0] din, trig_mask;
    logic [9:0] pre_count, post_count;
    logic wr_en_a, busy_a, done_a, wr_en_b, busy_b, done_b;
    logic [9:0] wr_addr_a, trig_addr_a;
    logic [3:0] wr_addr_b, trig_addr_b;
    logic [7:0] wr_data_a, wr_data_b;
    logic [17:0] q_a[$], q_b[$];
    logic [9:0] exp_ptr;
    int checks = 0, failures = 0, unexp = 0;

    capture_controller dut_a (
        .clk(clk), .rst(rst), .sample_en(sample_en), .din(din), .arm(arm), .abort(abort),
        .trig_mask(trig_mask), .trig_pol(trig_pol), .pre_count(pre_count), .post_count(post_count),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a), .trig_addr(trig_addr_a),
        .busy(busy_a), .done(done_a)
    );
    capture_controller #(.CHANNELS(8), .ADDR_W(4)) dut_b (
        .clk(clk), .rst(rst), .sample_en(sample_en), .din(din), .arm(arm), .abort(abort),
        .trig_mask(trig_mask), .trig_pol(trig_pol), .pre_count(pre_count[3:0]), .post_count(post_count[3:0]),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .trig_addr(trig_addr_b),
        .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wr_en_a) begin
            if (q_a.size() == 0) unexp++;
            else chk("wr_a", {14'd0, wr_addr_a, wr_data_a}, {14'd0, q_a.pop_front()});
        end
        if (wr_en_b) begin
            if (q_b.size() == 0) unexp++;
            else chk("wr_b", {14'd0, 6'd0, wr_addr_b, wr_data_b}, {14'd0, q_b.pop_front()});
        end
    end

    task automatic smp(input logic [7:0] d, input logic exp_wr);
        din = d;
        sample_en = 1'b1;
        if (exp_wr) begin
            q_a.push_back({exp_ptr, d});
            q_b.push_back({exp_ptr & 10'h00f, d});
            exp_ptr++;
        end
        @(posedge clk);
        #1 sample_en = 1'b0;
        chk("wr_en_a", wr_en_a, exp_wr);
        chk("wr_en_b", wr_en_b, exp_wr);
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [9:0] pre, input logic [9:0] post, input logic [7:0] m, input logic p);
        pre_count = pre;
        post_count = post;
        trig_mask = m;
        trig_pol = p;
        arm = 1'b1;
        @(posedge clk);
        #1 arm = 1'b0;
        exp_ptr = '0;
        chk("busy_after_arm", busy_a, 1);
    endtask

    task automatic fin(input string tag, input logic [9:0] ta);
        chk({tag, "_done_a"}, {done_a, busy_a}, 2'b10);
        chk({tag, "_done_b"}, {done_b, busy_b}, 2'b10);
        chk({tag, "_trig_a"}, trig_addr_a, ta);
        chk({tag, "_trig_b"}, trig_addr_b, ta & 10'h00f);
        chk({tag, "_drain"}, q_a.size() + q_b.size(), 0);
        chk({tag, "_unexp"}, unexp, 0);
    endtask

    initial begin
        rst = 1'b1; sample_en = 0; arm = 0; abort = 0; din = 0;
        trig_mask = 0; trig_pol = 0; pre_count = 0; post_count = 0; exp_ptr = 0;
        #12;
        chk("rst_a", {busy_a, done_a, wr_en_a, wr_addr_a, trig_addr_a, wr_data_a}, 0);
        chk("rst_b", {busy_b, done_b, wr_en_b, wr_addr_b, trig_addr_b, wr_data_b}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        // pre=4 post=3, ch0 rises on 7th sample
        go(4, 3, 8'h01, 0);
        for (int i = 1; i <= 10; i++) smp((i >= 7) ? 8'h01 : 8'h00, 1);
        fin("t2", 6);
        // restart from DONE, then async reset mid-POST
        go(4, 3, 8'h01, 0);
        for (int i = 1; i <= 8; i++) smp((i >= 7) ? 8'h01 : 8'h00, 1);
        chk("post_busy", busy_a, 1);
        #2 rst = 1'b1;
        #1 chk("rst_async", {busy_a, done_a, wr_en_a}, 0);
        @(posedge clk);
        #1;
        chk("rst_mid_a", {busy_a, done_a, wr_en_a, wr_addr_a, trig_addr_a, wr_data_a}, 0);
        chk("rst_mid_b", {busy_b, done_b, wr_en_b, wr_addr_b, trig_addr_b, wr_data_b}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        // pre=0 post=0, ch7 falls
        smp(8'h80, 0);
        go(0, 0, 8'h80, 1);
        smp(8'h00, 1);
        fin("t3", 0);
        smp(8'h80, 0);
        // pre=2, 20 waits with an ignored arm, then hit at sample 22
        go(2, 1, 8'h01, 0);
        for (int i = 0; i < 12; i++) smp(8'h00, 1);
        arm = 1'b1;
        @(posedge clk);
        #1 arm = 1'b0;
        chk("arm_ignored", busy_a, 1);
        for (int i = 0; i < 10; i++) smp(8'h00, 1);
        chk("wait_busy", {busy_a, busy_b}, 2'b11);
        smp(8'h01, 1);
        smp(8'h03, 1);
        fin("t4", 22);
        // mask=0 waits forever; abort+arm with a sample in the same clk
        go(2, 1, 8'h00, 0);
        for (int i = 0; i < 50; i++) smp(8'($urandom_range(0, 255)), 1);
        chk("mask0_busy", busy_a, 1);
        din = 8'h5a; sample_en = 1; abort = 1; arm = 1;
        @(posedge clk);
        #1 sample_en = 0; abort = 0; arm = 0;
        chk("abort_wr", {wr_en_a, wr_en_b}, 0);
        chk("abort_state", {busy_a, done_a, busy_b, done_b}, 0);
        smp(8'hff, 0);
        smp(8'h00, 0);
        go(2, 1, 8'h00, 0);
        smp(8'h33, 1);
        smp(8'h44, 1);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("end_idle", {busy_a, done_a}, 0);
        chk("end_drain", q_a.size() + q_b.size(), 0);
        chk("end_unexp", unexp, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
